// File: rtl/arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// State encoding, owner codes and default widths.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  localparam int ARB_ADDR_W   = 28;
  localparam int ARB_DATA_W   = 128;
  localparam int ARB_MAX_WAIT = 4;
  localparam int STAT_W       = 16;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating event counter used for arbiter statistics.
// Holds at all-ones once reached.
module arb_sat_counter
  import arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] cnt_q;
  logic [STAT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// I/D cache arbiter for the single main-memory block port.
// Statistics counters are built only when ARB_STATS_EN is defined.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        owner,
  output logic [15:0]       stat_i_grants,
  output logic [15:0]       stat_d_grants,
  output logic [15:0]       stat_i_wait
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] MAX_W = WCW'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [1:0]        owner_q, owner_d;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;

  assign d_req = d_read | d_write;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    owner_d     = owner_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // D wins unless I has already waited MAX_WAIT D grants
        if (d_req && (wait_q < MAX_W)) begin
          grant_d = 1'b1;
        end else if (i_read) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end

        if (!i_read) begin
          wait_d = '0;
        end

        if (grant_d) begin
          state_d     = GRANT_D;
          owner_d     = OWN_D;
          mem_write_d = d_write;
          mem_read_d  = ~d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (i_read && (wait_q < MAX_W)) begin
            wait_d = wait_q + WCW'(1);
          end
        end else if (grant_i) begin
          state_d     = GRANT_I;
          owner_d     = OWN_I;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_addr;
          wait_d      = '0;
        end
      end

      GRANT_I, GRANT_D: begin
        if (mem_ready) begin
          state_d     = RELEASE;
          owner_d     = OWN_NONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == GRANT_I) begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_ready_d = 1'b1;
            if (mem_read_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      owner_q     <= OWN_NONE;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      owner_q     <= owner_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign owner     = owner_q;

`ifdef ARB_STATS_EN
  logic i_wait_inc;

  assign i_wait_inc = i_read & (owner_q != OWN_I);

  arb_sat_counter u_cnt_i_grants (
    .clk   (clk),
    .rst   (rst),
    .inc   (grant_i),
    .count (stat_i_grants)
  );

  arb_sat_counter u_cnt_d_grants (
    .clk   (clk),
    .rst   (rst),
    .inc   (grant_d),
    .count (stat_d_grants)
  );

  arb_sat_counter u_cnt_i_wait (
    .clk   (clk),
    .rst   (rst),
    .inc   (i_wait_inc),
    .count (stat_i_wait)
  );
`else
  assign stat_i_grants = '0;
  assign stat_d_grants = '0;
  assign stat_i_wait   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cache traffic,
// memory responder and output monitor in separate processes.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    own;
  } mem_exp_t;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] wdata;
  } dop_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    owner;
  logic [15:0]   stat_i_grants;
  logic [15:0]   stat_d_grants;
  logic [15:0]   stat_i_wait;

  mem_port_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_read        (i_read),
    .i_addr        (i_addr),
    .i_rdata       (i_rdata),
    .i_ready       (i_ready),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_rdata       (d_rdata),
    .d_ready       (d_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .owner         (owner),
    .stat_i_grants (stat_i_grants),
    .stat_d_grants (stat_d_grants),
    .stat_i_wait   (stat_i_wait)
  );

  always #5 clk = ~clk;

  mem_exp_t      exp_mem[$];
  logic [DW-1:0] exp_i[$];
  logic [DW-1:0] exp_d[$];
  logic [AW-1:0] i_ops[$];
  dop_t          d_ops[$];

  int            n_chk = 0;
  int            n_pass = 0;
  int            n_fail = 0;
  int            lat_cfg = 3;
  int            last_gap = 0;
  bit            spur_req = 1'b0;
  bit            snap = 1'b0;
  logic [DW-1:0] d_last;

  function automatic logic [DW-1:0] blk(input logic [AW-1:0] a);
    return {16'hDEAD, 80'h0, 32'(a >> 4)};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_rdata"}, {i_rdata, d_rdata}, '0);
    chk({nm, "_wdata"}, mem_wdata, '0);
    chk({nm, "_ctrl"},
        {i_ready, d_ready, mem_read, mem_write, mem_addr, owner,
         stat_i_grants, stat_d_grants, stat_i_wait}, '0);
  endtask

  task automatic apply();
    dop_t o;
    i_read = (i_ops.size() > 0);
    i_addr = i_read ? i_ops[0] : '0;
    if (d_ops.size() > 0) begin
      o       = d_ops[0];
      d_read  = o.rd;
      d_write = o.wr;
      d_addr  = o.wr ? o.waddr : o.raddr;
      d_wdata = o.wdata;
    end else begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end
  endtask

  // Requester side: drop or advance a request once its ready is seen.
  task automatic step();
    dop_t o;
    @(negedge clk);
    if (i_ready && (i_ops.size() > 0)) begin
      if (snap) begin
        snap = 1'b0;
`ifdef ARB_STATS_EN
        chk("snap_stats", {stat_i_grants, stat_d_grants, stat_i_wait},
            {16'd1, 16'd4, 16'd21});
`else
        chk("snap_stats", {stat_i_grants, stat_d_grants, stat_i_wait},
            '0);
`endif
      end
      void'(i_ops.pop_front());
    end
    if (d_ready && (d_ops.size() > 0)) begin
      o = d_ops[0];
      if (o.wr && o.rd) begin
        o.wr     = 1'b0;
        d_ops[0] = o;
      end else begin
        void'(d_ops.pop_front());
      end
    end
    apply();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((i_ops.size() + d_ops.size() + exp_mem.size() +
            exp_i.size() + exp_d.size()) != 0) begin
      step();
      n++;
      if (n > 400) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_timeout: got pending work want none", nm);
        i_ops.delete();
        d_ops.delete();
        exp_mem.delete();
        exp_i.delete();
        exp_d.delete();
        apply();
        break;
      end
    end
    repeat (4) step();
  endtask

  // Monitor and memory responder.
  initial begin : mon
    logic          strobe;
    logic          strobe_prev;
    logic          busy;
    logic          mr_prev;
    logic          ir_prev;
    logic          dr_prev;
    logic [AW-1:0] cur;
    logic [DW-1:0] wd_act;
    logic [DW-1:0] wd_exp;
    logic [DW-1:0] rd_exp;
    mem_exp_t      e;
    int            cnt;
    int            cyc;
    int            last_done;
    strobe_prev = 1'b0;
    busy        = 1'b0;
    ir_prev     = 1'b0;
    dr_prev     = 1'b0;
    cur         = '0;
    cnt         = 0;
    cyc         = 0;
    last_done   = -100;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mr_prev = mem_ready;
      if (!rst) begin
        busy        = 1'b0;
        strobe_prev = 1'b0;
        ir_prev     = 1'b0;
        dr_prev     = 1'b0;
        last_done   = -100;
        mem_ready   = 1'b0;
      end else begin
        strobe = mem_read | mem_write;
        chk("excl", {mem_read, mem_write} == 2'b11, 0);
        if (strobe && strobe_prev) begin
          chk("hold_addr", mem_addr, cur);
        end
        if (strobe && !strobe_prev) begin
          if (exp_mem.size() == 0) begin
            chk("mem_unexp", {mem_write, mem_addr}, 0);
          end else begin
            e      = exp_mem.pop_front();
            wd_act = e.wr ? mem_wdata : '0;
            wd_exp = e.wr ? e.wdata : '0;
            chk("mem_req", {owner, mem_write, mem_addr, wd_act},
                {e.own, e.wr, e.addr, wd_exp});
            last_gap = cyc - last_done;
            chk("gap", last_gap >= 2, 1);
          end
          busy = 1'b1;
          cnt  = lat_cfg;
          cur  = mem_addr;
        end
        if (i_ready) begin
          if (exp_i.size() == 0) begin
            chk("i_unexp", i_rdata, 0);
          end else begin
            rd_exp = exp_i.pop_front();
            chk("i_rdata", i_rdata, rd_exp);
          end
          chk("i_timing", {mr_prev, strobe, ir_prev}, 3'b100);
          last_done = cyc;
        end
        if (d_ready) begin
          if (exp_d.size() == 0) begin
            chk("d_unexp", d_rdata, 0);
          end else begin
            rd_exp = exp_d.pop_front();
            chk("d_rdata", d_rdata, rd_exp);
          end
          chk("d_timing", {mr_prev, strobe, dr_prev}, 3'b100);
          last_done = cyc;
        end
        mem_ready = 1'b0;
        if (busy) begin
          cnt--;
          if (cnt <= 0) begin
            mem_ready = 1'b1;
            mem_rdata = blk(cur);
            busy      = 1'b0;
          end
        end else if (spur_req) begin
          mem_ready = 1'b1;
          mem_rdata = '1;
        end
        strobe_prev = strobe;
        ir_prev     = i_ready;
        dr_prev     = d_ready;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst     = 1'b0;
    i_read  = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_last  = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    #2 rst = 1'b1;

    // I-only read, memory answers after 5 cycles
    lat_cfg = 5;
    i_ops.push_back(28'h0000010);
    exp_mem.push_back('{wr: 1'b0, addr: 28'h0000010, wdata: '0,
                        own: OWN_I});
    exp_i.push_back(128'hDEAD_0000_0000_0000_0000_0000_0000_0001);
    step();
    @(negedge clk);
    chk("i_lat", {mem_read, mem_write, mem_addr, owner},
        {2'b10, 28'h0000010, OWN_I});
    drain("s1");

    // Same-cycle I read and D write: D first
    lat_cfg = 2;
    d_ops.push_back('{rd: 1'b0, wr: 1'b1, waddr: 28'h0000200,
                      raddr: 28'h0000200,
                      wdata: 128'h1111_2222_3333_4444_5555_6666_7777_8888});
    i_ops.push_back(28'h0000030);
    exp_mem.push_back('{wr: 1'b1, addr: 28'h0000200,
                        wdata: 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                        own: OWN_D});
    exp_mem.push_back('{wr: 1'b0, addr: 28'h0000030, wdata: '0,
                        own: OWN_I});
    exp_d.push_back(d_last);
    exp_i.push_back(blk(28'h0000030));
    step();
    drain("s2");
    chk("s2_gap", last_gap, 2);

    // Starvation bound from a clean reset
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    d_last  = '0;
    lat_cfg = 3;
    for (int k = 0; k < 6; k++) begin
      d_ops.push_back('{rd: 1'b1, wr: 1'b0, waddr: '0,
                        raddr: 28'h0000100 + 28'(k * 16), wdata: '0});
    end
    i_ops.push_back(28'h0000050);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        exp_mem.push_back('{wr: 1'b0, addr: 28'h0000050, wdata: '0,
                            own: OWN_I});
      end
      exp_mem.push_back('{wr: 1'b0, addr: 28'h0000100 + 28'(k * 16),
                          wdata: '0, own: OWN_D});
      exp_d.push_back(blk(28'h0000100 + 28'(k * 16)));
    end
    d_last = blk(28'h0000150);
    exp_i.push_back(blk(28'h0000050));
    snap = 1'b1;
    step();
    drain("s3");
    chk("s3_gap", last_gap, 2);
    chk("s3_snap_taken", snap, 0);
`ifdef ARB_STATS_EN
    chk("s3_stats", {stat_i_grants, stat_d_grants, stat_i_wait},
        {16'd1, 16'd6, 16'd21});
`else
    chk("s3_stats", {stat_i_grants, stat_d_grants, stat_i_wait}, '0);
`endif

    // Write-back then refill from one D request
    lat_cfg = 2;
    d_ops.push_back('{rd: 1'b1, wr: 1'b1, waddr: 28'h0000300,
                      raddr: 28'h0000340,
                      wdata: 128'hCAFE_F00D_0123_4567_89AB_CDEF_0F0F_F0F0});
    exp_mem.push_back('{wr: 1'b1, addr: 28'h0000300,
                        wdata: 128'hCAFE_F00D_0123_4567_89AB_CDEF_0F0F_F0F0,
                        own: OWN_D});
    exp_mem.push_back('{wr: 1'b0, addr: 28'h0000340, wdata: '0,
                        own: OWN_D});
    exp_d.push_back(d_last);
    exp_d.push_back(blk(28'h0000340));
    d_last = blk(28'h0000340);
    step();
    drain("s4");

    // mem_ready while idle must be ignored
    spur_req = 1'b1;
    repeat (3) step();
    spur_req = 1'b0;
    repeat (2) step();
    chk("idle_quiet", {mem_read, mem_write, owner, i_ready, d_ready},
        0);
    chk("idle_rdata", d_rdata, d_last);

    // Asynchronous reset during a D grant
    lat_cfg = 30;
    d_ops.push_back('{rd: 1'b1, wr: 1'b0, waddr: '0,
                      raddr: 28'h0000400, wdata: '0});
    exp_mem.push_back('{wr: 1'b0, addr: 28'h0000400, wdata: '0,
                        own: OWN_D});
    step();
    step();
    step();
    chk("pre_rst", {mem_read, owner}, {1'b1, OWN_D});
    #2 rst = 1'b0;
    #1 chk_zero_outputs("async_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    d_last  = '0;
    lat_cfg = 2;
    exp_mem.push_back('{wr: 1'b0, addr: 28'h0000400, wdata: '0,
                        own: OWN_D});
    exp_d.push_back(blk(28'h0000400));
    d_last = blk(28'h0000400);
    drain("s6");

    chk("sb_empty", {exp_mem.size(), exp_i.size(), exp_d.size()}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single main-memory port between the I-cache refill path and the D-cache refill/write-back path of the pipelined CPU. It serializes block transactions, fixes ownership for each transaction and returns the memory ready/data to the owning cache. D-side requests have priority. A bounded-wait rule prevents instruction-fetch starvation during long store-heavy loops such as the bubble-sort workloads.

Parameters:
ADDR_W, 28, block address width (30-bit word address, 4-word blocks)
DATA_W, 128, block data width
MAX_WAIT, 4, consecutive D grants allowed while I is pending before I is forced

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
i_read  input  1  I-cache block read request, held until i_ready
i_addr  input  ADDR_W  I-cache block address
i_rdata  output  DATA_W  block returned to I-cache
i_ready  output  1  one-cycle completion pulse to I-cache
d_read  input  1  D-cache block read request, held until d_ready
d_write  input  1  D-cache write-back request, held until d_ready
d_addr  input  ADDR_W  D-cache block address
d_wdata  input  DATA_W  write-back block
d_rdata  output  DATA_W  block returned to D-cache
d_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory block address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
mem_ready  input  1  memory completion, may assert any cycle after strobe
owner  output  2  00 none, 01 I, 10 D (debug/trace)
stat_i_grants  output  16  see Optional Feature
stat_d_grants  output  16  see Optional Feature
stat_i_wait  output  16  see Optional Feature

Behaviour:
- All outputs are registered. Reset: state IDLE, every output 0, wait counter 0.
- The reset is asynchronous and active-low. Asserting it mid-transaction aborts the transaction immediately: strobes drop to 0 and no ready pulse is issued.
- FSM states: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE, arbitration:
  - If d_read|d_write and wait_cnt<MAX_WAIT, go to GRANT_D.
  - Else if i_read, go to GRANT_I.
  - Else if d_read|d_write (only possible with wait_cnt==MAX_WAIT and no i_read), go to GRANT_D.
- On grant, the block latches the address, the data and the operation. For D, d_write takes precedence over d_read when both are high. The D-cache keeps d_read high after the write-back's d_ready, and that read is served as a later transaction.
- Latency: a request sampled in IDLE at cycle t produces the strobe and mem_addr at t+1.
- Strobes and latched address/data stay constant until mem_ready is sampled high.
- mem_ready sampled at cycle k:
  - Strobes drop at k+1.
  - The owner's ready pulses high for exactly one cycle at k+1.
  - The owner's rdata is registered from mem_rdata at k and holds until the next read completion. Writes leave d_rdata unchanged.
  - The FSM goes to RELEASE.
- RELEASE lasts one cycle with both strobes low, so the requester can drop its request, then returns to IDLE. Minimum spacing between transactions is therefore 2 idle strobe cycles.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on each GRANT_D entry while i_read is high.
  - Clears on GRANT_I entry, and in IDLE whenever i_read is low.
- If a request drops mid-transaction, the transaction still completes and the ready pulse is still issued.
- owner reflects GRANT_I/GRANT_D and is 00 in IDLE and RELEASE.
- mem_ready while IDLE or RELEASE is ignored.
- mem_read and mem_write are never high together.

Optional Feature:
ARB_STATS_EN:
- Defined: three 16-bit saturating counters (stop at 0xFFFF), all cleared by reset.
  - stat_i_grants counts GRANT_I entries.
  - stat_d_grants counts GRANT_D entries.
  - stat_i_wait counts cycles with i_read high and owner != 01.
- Undefined: the counter logic is absent and the three ports are tied to 0. The port list is identical in both builds.

Decomposition:
- Package arb_pkg holds:
  - state encoding constants (IDLE=2'd0, GRANT_I=2'd1, GRANT_D=2'd2, RELEASE=2'd3)
  - owner codes (OWN_NONE, OWN_I, OWN_D)
  - default widths
- One sub-module, arb_sat_counter: a 16-bit saturating counter with inc enable, instantiated three times under ARB_STATS_EN.

Test Plan:
- I-only read: i_read=1, i_addr=0x0000010, memory ready after 5 cycles with 0xDEAD...0001.
  - mem_read rises 1 cycle after the request, mem_addr=0x0000010.
  - i_ready pulses one cycle with i_rdata=0xDEAD...0001; d_ready stays 0.
- Simultaneous i_read and d_write in the same cycle: D is granted first (mem_write=1, mem_wdata=d_wdata). After D's ready and one RELEASE cycle, I is granted.
- Starvation bound with MAX_WAIT=4: d_read is held continuously with back-to-back D requests while i_read is held. Exactly 4 D grants occur, the 5th grant goes to I, then D resumes.
- Write-back then refill: d_write and d_read are both high. The write is served first with d_rdata unchanged. The read follows with d_rdata equal to the memory block. There are two d_ready pulses in total.
- Reset mid-transaction: rst low during GRANT_D before mem_ready. Outputs clear to 0 asynchronously, no d_ready is issued, and after release the block returns to IDLE with the pending request re-arbitrated.
- ARB_STATS_EN: after the starvation scenario, stat_d_grants=4 and stat_i_grants=1. stat_i_wait equals the measured number of cycles I waited.
